// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared constants and state encoding for the SPI master transfer sequencer.
package spi_xfer_ctrl_pkg;

    localparam int SPI_DIVIDER_LEN = 16;
    localparam int SPI_SS_NB       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } xfer_state_t;

    // A transfer may end once the shift register is exhausted and sclk is back at idle.
    // A divider tick in that state cannot move sclk, so it does not hold the exit off;
    // this keeps divider=0, where every cycle ticks, from stalling forever.
    function automatic logic xfer_done(input logic last, input logic sclk);
        return last && !sclk;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Programmable sclk generator: half-period counter, sclk flop and edge strobes.
module spi_clk_div
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int DIVIDER_LEN = SPI_DIVIDER_LEN
) (
    input  logic                   wb_clk,
    input  logic                   wb_reset,
    input  logic                   enable,
    input  logic                   load,
    input  logic                   last,
    input  logic [DIVIDER_LEN-1:0] divider,
    output logic                   sclk,
    output logic                   cpol_0,
    output logic                   cpol_1
);

    logic [DIVIDER_LEN-1:0] cnt;
    logic                   tick;

    assign tick = enable && (cnt == '0);

    // The divider is only sampled on a reload, so a mid-transfer change lands at the next tick.
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= divider;
        end else if (enable) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Once last is up only a pending falling edge may still happen.
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            sclk <= 1'b0;
        end else if (load) begin
            sclk <= 1'b0;
        end else if (tick && (!last || sclk)) begin
            sclk <= ~sclk;
        end
    end

    assign cpol_0 = tick && !sclk && !last;
    assign cpol_1 = tick && sclk;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: GO handling, transfer FSM, slave selects and completion irq.
module spi_xfer_ctrl
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int DIVIDER_LEN = SPI_DIVIDER_LEN,
    parameter int SS_NB       = SPI_SS_NB
) (
    input  logic                   wb_clk,
    input  logic                   wb_reset,
    input  logic                   go_set,
    input  logic [DIVIDER_LEN-1:0] divider,
    input  logic                   last,
    input  logic                   ie,
    input  logic                   ass,
    input  logic [SS_NB-1:0]       ss_reg,
    input  logic                   int_ack,
    output logic                   tip,
    output logic                   sclk,
    output logic                   cpol_0,
    output logic                   cpol_1,
    output logic [SS_NB-1:0]       ss_pad_o,
    output logic                   irq
);

    xfer_state_t state;
    xfer_state_t state_next;
    logic        load;
    logic        xfer_exit;

    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // go_set is only honoured from IDLE, so requests during a transfer are simply dropped.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        xfer_exit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (go_set) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load       = 1'b1;
                state_next = XFER;
            end
            XFER: begin
                if (xfer_done(last, sclk)) begin
                    xfer_exit  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tip = (state != IDLE);

    // A completion in the same cycle as an acknowledge keeps the interrupt pending.
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            irq <= 1'b0;
        end else if (xfer_exit && ie) begin
            irq <= 1'b1;
        end else if (int_ack) begin
            irq <= 1'b0;
        end
    end

    // Selects are forced inactive during reset even when ass=0 would otherwise drive them.
    assign ss_pad_o = wb_reset ? {SS_NB{1'b1}}
                               : ~(ss_reg & {SS_NB{ass ? tip : 1'b1}});

    spi_clk_div #(
        .DIVIDER_LEN(DIVIDER_LEN)
    ) u_clk_div (
        .wb_clk  (wb_clk),
        .wb_reset(wb_reset),
        .enable  (state == XFER),
        .load    (load),
        .last    (last),
        .divider (divider),
        .sclk    (sclk),
        .cpol_0  (cpol_0),
        .cpol_1  (cpol_1)
    );

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed self-checking bench for spi_xfer_ctrl with a small bit-counting shift register model.
module tb_spi_xfer_ctrl;

    logic        wb_clk   = 1'b0;
    logic        wb_reset = 1'b1;
    logic        go_set   = 1'b0;
    logic [15:0] divider  = 16'd0;
    logic        last     = 1'b0;
    logic        ie       = 1'b0;
    logic        ass      = 1'b0;
    logic [7:0]  ss_reg   = 8'h00;
    logic        int_ack  = 1'b0;
    logic        tip;
    logic        sclk;
    logic        cpol_0;
    logic        cpol_1;
    logic [7:0]  ss_pad_o;
    logic        irq;

    int checks = 0;
    int errors = 0;

    int   tip_cycles, n_rise, n_fall, n_both, n_alt_bad, n_edges, ss_bad, bits_left;
    int   gaps [64];
    logic timed_out, irq_end, sclk_end;
    logic [7:0] ss_exp = 8'hFF;

    spi_xfer_ctrl #(
        .DIVIDER_LEN(16),
        .SS_NB      (8)
    ) dut (
        .wb_clk  (wb_clk),
        .wb_reset(wb_reset),
        .go_set  (go_set),
        .divider (divider),
        .last    (last),
        .ie      (ie),
        .ass     (ass),
        .ss_reg  (ss_reg),
        .int_ack (int_ack),
        .tip     (tip),
        .sclk    (sclk),
        .cpol_0  (cpol_0),
        .cpol_1  (cpol_1),
        .ss_pad_o(ss_pad_o),
        .irq     (irq)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    // Pulses go_set and follows the transfer until tip drops; last counts down on rising strobes.
    task automatic run_xfer(input int div, input int len, input int go_at,
                            input int div_at, input int div_new, input int ack_at);
        int   cyc;
        int   last_edge;
        logic rise_seen;
        tip_cycles = 0; n_rise = 0; n_fall = 0; n_both = 0;
        n_alt_bad  = 0; n_edges = 0; ss_bad = 0;
        cyc = 0; last_edge = 0;
        divider   = div[15:0];
        bits_left = len;
        last      = (len == 0);
        go_set    = 1'b1;
        step();
        go_set = 1'b0;
        while (tip === 1'b1 && cyc < 500) begin
            #1;
            tip_cycles++;
            if (ss_pad_o !== ss_exp) ss_bad++;
            if (cpol_0 === 1'b1 && cpol_1 === 1'b1) n_both++;
            if (cpol_0 === 1'b1 || cpol_1 === 1'b1) begin
                if ((n_edges % 2 == 0) != (cpol_0 === 1'b1)) n_alt_bad++;
                if (n_edges > 0 && n_edges <= 64) gaps[n_edges-1] = cyc - last_edge;
                last_edge = cyc;
                n_edges++;
            end
            if (cpol_0 === 1'b1) n_rise++;
            if (cpol_1 === 1'b1) n_fall++;
            rise_seen = cpol_0;
            if (cyc == go_at) go_set = 1'b1;
            if (cyc == div_at) divider = div_new[15:0];
            if (cyc == ack_at) int_ack = 1'b1;
            step();
            go_set  = 1'b0;
            int_ack = 1'b0;
            if (rise_seen === 1'b1 && bits_left > 0) bits_left--;
            last = (bits_left == 0);
            cyc++;
        end
        timed_out = (tip !== 1'b0);
        irq_end   = irq;
        sclk_end  = sclk;
    endtask

    task automatic test_reset();
        ss_reg = 8'h05;
        ass    = 1'b0;
        #1;
        checks++; if (tip !== 1'b0) begin errors++; $display("[TB] FAIL reset_tip: got %b expected 0", tip); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        checks++; if ({cpol_0, cpol_1} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 00", {cpol_0, cpol_1}); end
        checks++; if (ss_pad_o !== 8'hFF) begin errors++; $display("[TB] FAIL reset_ss: got %h expected ff", ss_pad_o); end
        step();
        wb_reset = 1'b0;
        step();
        checks++; if (tip !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_tip: got %b expected 0", tip); end
    endtask

    task automatic test_basic_timing();
        int bad;
        ie = 1'b1; ass = 1'b1; ss_reg = 8'h05; ss_exp = 8'hFA;
        run_xfer(1, 8, -1, -1, 0, -1);
        bad = 0;
        for (int i = 0; i < n_edges - 1; i++) if (gaps[i] != 2) bad++;
        checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout: tip still %b", tip); end
        checks++; if (tip_cycles != 34) begin errors++; $display("[TB] FAIL basic_tip_len: got %0d expected 34", tip_cycles); end
        checks++; if (n_rise != 8) begin errors++; $display("[TB] FAIL basic_rise: got %0d expected 8", n_rise); end
        checks++; if (n_fall != 8) begin errors++; $display("[TB] FAIL basic_fall: got %0d expected 8", n_fall); end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL basic_half_period: %0d gaps differ from 2", bad); end
        checks++; if (irq_end !== 1'b1) begin errors++; $display("[TB] FAIL basic_irq: got %b expected 1", irq_end); end
        checks++; if (sclk_end !== 1'b0) begin errors++; $display("[TB] FAIL basic_sclk_end: got %b expected 0", sclk_end); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL basic_irq_ack: got %b expected 0", irq); end
    endtask

    task automatic test_fast_divider();
        int bad;
        ie = 1'b0;
        run_xfer(0, 8, -1, -1, 0, -1);
        bad = 0;
        for (int i = 0; i < n_edges - 1; i++) if (gaps[i] != 1) bad++;
        checks++; if (tip_cycles != 18) begin errors++; $display("[TB] FAIL fast_tip_len: got %0d expected 18", tip_cycles); end
        checks++; if (n_edges != 16) begin errors++; $display("[TB] FAIL fast_edges: got %0d expected 16", n_edges); end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL fast_toggle: %0d gaps differ from 1", bad); end
        checks++; if (n_alt_bad != 0) begin errors++; $display("[TB] FAIL fast_alternate: got %0d out-of-order strobes expected 0", n_alt_bad); end
        checks++; if (n_both != 0) begin errors++; $display("[TB] FAIL fast_coincident: got %0d expected 0", n_both); end
        checks++; if (irq_end !== 1'b0) begin errors++; $display("[TB] FAIL fast_irq_ie0: got %b expected 0", irq_end); end
    endtask

    task automatic test_slave_select();
        ass = 1'b1; ss_reg = 8'h05; ss_exp = 8'hFA;
        #1;
        checks++; if (ss_pad_o !== 8'hFF) begin errors++; $display("[TB] FAIL ss_auto_idle: got %h expected ff", ss_pad_o); end
        run_xfer(0, 1, -1, -1, 0, -1);
        checks++; if (ss_bad != 0) begin errors++; $display("[TB] FAIL ss_auto_active: got %0d bad cycles expected 0", ss_bad); end
        checks++; if (ss_pad_o !== 8'hFF) begin errors++; $display("[TB] FAIL ss_auto_after: got %h expected ff", ss_pad_o); end
        ass = 1'b0;
        #1;
        checks++; if (ss_pad_o !== 8'hFA) begin errors++; $display("[TB] FAIL ss_manual_idle: got %h expected fa", ss_pad_o); end
        run_xfer(0, 1, -1, -1, 0, -1);
        checks++; if (ss_bad != 0) begin errors++; $display("[TB] FAIL ss_manual_active: got %0d bad cycles expected 0", ss_bad); end
        ass = 1'b1;
    endtask

    task automatic test_go_ignored_irq_race();
        ie = 1'b1;
        run_xfer(1, 8, 10, -1, 0, 33);
        checks++; if (n_edges != 16) begin errors++; $display("[TB] FAIL go_mid_edges: got %0d expected 16", n_edges); end
        checks++; if (tip_cycles != 34) begin errors++; $display("[TB] FAIL go_mid_tip_len: got %0d expected 34", tip_cycles); end
        checks++; if (irq_end !== 1'b1) begin errors++; $display("[TB] FAIL irq_set_wins: got %b expected 1", irq_end); end
        ie = 1'b0;
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_ie_clear_keeps: got %b expected 1", irq); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_late_ack: got %b expected 0", irq); end
        run_xfer(1, 8, 33, -1, 0, -1);
        step(); step(); step();
        checks++; if (tip !== 1'b0) begin errors++; $display("[TB] FAIL go_at_exit: tip got %b expected 0", tip); end
    endtask

    task automatic test_divider_change();
        int bad;
        run_xfer(1, 8, -1, 5, 3, -1);
        bad = 0;
        for (int i = 0; i < n_edges - 1; i++) if (gaps[i] != ((i < 2) ? 2 : 4)) bad++;
        checks++; if (n_edges != 16) begin errors++; $display("[TB] FAIL divchg_edges: got %0d expected 16", n_edges); end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL divchg_half_period: %0d gaps differ from 2,2,4..", bad); end
        checks++; if (tip_cycles != 60) begin errors++; $display("[TB] FAIL divchg_tip_len: got %0d expected 60", tip_cycles); end
    endtask

    task automatic test_len_zero();
        ie = 1'b1;
        run_xfer(2, 0, -1, -1, 0, -1);
        checks++; if (tip_cycles != 2) begin errors++; $display("[TB] FAIL len0_tip_len: got %0d expected 2", tip_cycles); end
        checks++; if (n_edges != 0) begin errors++; $display("[TB] FAIL len0_edges: got %0d expected 0", n_edges); end
        checks++; if (irq_end !== 1'b1) begin errors++; $display("[TB] FAIL len0_irq: got %b expected 1", irq_end); end
    endtask

    task automatic test_reset_mid_xfer();
        int strobes;
        ass = 1'b0; ss_reg = 8'h05;
        divider = 16'd3; last = 1'b0;
        go_set = 1'b1; step(); go_set = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (sclk !== 1'b1) begin errors++; $display("[TB] FAIL midrst_sclk_before: got %b expected 1", sclk); end
        #2;
        wb_reset = 1'b1;
        #1;
        checks++; if (tip !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tip: got %b expected 0", tip); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sclk: got %b expected 0", sclk); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL midrst_irq: got %b expected 0", irq); end
        checks++; if (ss_pad_o !== 8'hFF) begin errors++; $display("[TB] FAIL midrst_ss: got %h expected ff", ss_pad_o); end
        step();
        wb_reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cpol_0 === 1'b1 || cpol_1 === 1'b1 || tip === 1'b1) strobes++;
        end
        checks++; if (strobes != 0) begin errors++; $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", strobes); end
    endtask

    initial begin
        $display("[TB] starting spi_xfer_ctrl bench");
        test_reset();
        test_basic_timing();
        test_fast_divider();
        test_slave_select();
        test_go_ignored_irq_race();
        test_divider_change();
        test_len_zero();
        test_reset_mid_xfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
